// File: rtl/sad_min_tracker.sv
// sad_min_tracker: pipelined minimum-SAD tracker for motion estimation.
// Each beat carries NUM_LANES candidate SADs. Stage 1 reduces a beat to its
// best masked lane and computes that lane's tag. Stage 2 folds the winner
// into a running minimum/tag pair that spans a search framed by start/cand_last.
//
// Handshake: cand_valid marks a beat as present in the cycle it is high.
// There is no ready signal. A beat is always accepted on the edge where
// cand_valid=1, and cand_last/lane_mask/base_tag/tag_stride are sampled with it.
// result_valid is a one-cycle qualifier. While it is high, min_sad, min_tag
// and found hold the final result of the search.
module sad_min_tracker #(
  parameter int NUM_LANES = 2,
  parameter int SAD_WIDTH = 13,
  parameter int TAG_WIDTH = 32
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           start,
  input  logic                           cand_valid,
  input  logic                           cand_last,
  input  logic [NUM_LANES*SAD_WIDTH-1:0] cand_sad,
  input  logic [NUM_LANES-1:0]           lane_mask,
  input  logic [TAG_WIDTH-1:0]           base_tag,
  input  logic [TAG_WIDTH-1:0]           tag_stride,
  input  logic                           read_sel,
  output logic [31:0]                    read_data,
  output logic [SAD_WIDTH-1:0]           min_sad,
  output logic [TAG_WIDTH-1:0]           min_tag,
  output logic                           found,
  output logic                           busy,
  output logic                           result_valid
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  // Beat reduction results (combinational)
  logic                 red_any;
  logic [SAD_WIDTH-1:0] red_sad;
  logic [IDX_W-1:0]     red_idx;
  logic [SAD_WIDTH-1:0] lane_sad;
  logic [TAG_WIDTH-1:0] red_tag;

  // Stage-1 registers
  logic                 s1_valid;
  logic                 s1_last;
  logic [SAD_WIDTH-1:0] s1_sad;
  logic [TAG_WIDTH-1:0] s1_tag;

  // Priority scan over the masked lanes. The comparison is strict, so a later
  // lane only wins when its SAD is smaller. On a tie the lowest index is kept.
  always_comb begin
    red_any  = 1'b0;
    red_sad  = '1;
    red_idx  = '0;
    lane_sad = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_sad = cand_sad[i*SAD_WIDTH +: SAD_WIDTH];
      if (lane_mask[i] && (!red_any || (lane_sad < red_sad))) begin
        red_any = 1'b1;
        red_sad = lane_sad;
        red_idx = IDX_W'(i);
      end
    end
  end

  // The winning tag is base_tag + idx*tag_stride, built as a shift-add over
  // the index bits. It wraps naturally modulo 2^TAG_WIDTH.
  always_comb begin
    red_tag = base_tag;
    for (int b = 0; b < IDX_W; b++) begin
      if (red_idx[b]) begin
        red_tag = red_tag + (tag_stride << b);
      end
    end
  end

  // Stage 1 registers the beat winner. A fully masked beat still carries its
  // last flag, so the search can terminate on it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sad   <= '0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= cand_valid & red_any;
      s1_last  <= cand_valid & cand_last;
      if (cand_valid && red_any) begin
        s1_sad <= red_sad;
        s1_tag <= red_tag;
      end
    end
  end

  // Stage 2 folds into the running minimum. start clears the running state and
  // drops whatever is in stage 1, including its last flag. The beat that
  // arrives with start is already in stage 1's input and is kept for the new search.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      min_sad      <= '1;
      min_tag      <= '0;
      found        <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else if (start) begin
      min_sad      <= '1;
      min_tag      <= '0;
      found        <= 1'b0;
      busy         <= 1'b1;
      result_valid <= 1'b0;
    end else begin
      if (s1_valid && (s1_sad < min_sad)) begin
        min_sad <= s1_sad;
        min_tag <= s1_tag;
        found   <= 1'b1;
      end
      result_valid <= s1_last;
      if (s1_last) begin
        busy <= 1'b0;
      end
    end
  end

  // Memory-side readback: zero-extended view of the registered min or tag.
  always_comb begin
    read_data = '0;
    if (read_sel) begin
      read_data[SAD_WIDTH-1:0] = min_sad;
    end else begin
      read_data[TAG_WIDTH-1:0] = min_tag;
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// tb_sad_min_tracker: directed bench for sad_min_tracker. A schedule-based
// behavioural model predicts every output on every cycle. A scoreboard checks
// each search result of the back-to-back run. Literal expectations pin the model.
module tb_sad_min_tracker;

  localparam int NL = 4;
  localparam int SW = 13;
  localparam int TW = 32;
  localparam int QW = SW + TW + 1;
  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic              Reset;
  logic              start, cand_valid, cand_last, read_sel;
  logic [NL*SW-1:0]  cand_sad;
  logic [NL-1:0]     lane_mask;
  logic [TW-1:0]     base_tag, tag_stride;
  logic [31:0]       read_data;
  logic [SW-1:0]     min_sad;
  logic [TW-1:0]     min_tag;
  logic              found, busy, result_valid;

  sad_min_tracker #(.NUM_LANES(NL), .SAD_WIDTH(SW), .TAG_WIDTH(TW)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .cand_valid(cand_valid),
    .cand_last(cand_last), .cand_sad(cand_sad), .lane_mask(lane_mask),
    .base_tag(base_tag), .tag_stride(tag_stride), .read_sel(read_sel),
    .read_data(read_data), .min_sad(min_sad), .min_tag(min_tag),
    .found(found), .busy(busy), .result_valid(result_valid)
  );

  // Two-lane instance for the two-candidate case
  logic              d2_start, d2_valid, d2_last, d2_read_sel;
  logic [2*SW-1:0]   d2_sad;
  logic [1:0]        d2_mask;
  logic [TW-1:0]     d2_base, d2_stride;
  logic [31:0]       d2_read_data;
  logic [SW-1:0]     d2_min_sad;
  logic [TW-1:0]     d2_min_tag;
  logic              d2_found, d2_busy, d2_rv;

  sad_min_tracker #(.NUM_LANES(2), .SAD_WIDTH(SW), .TAG_WIDTH(TW)) dut2 (
    .Clk(Clk), .Reset(Reset), .start(d2_start), .cand_valid(d2_valid),
    .cand_last(d2_last), .cand_sad(d2_sad), .lane_mask(d2_mask),
    .base_tag(d2_base), .tag_stride(d2_stride), .read_sel(d2_read_sel),
    .read_data(d2_read_data), .min_sad(d2_min_sad), .min_tag(d2_min_tag),
    .found(d2_found), .busy(d2_busy), .result_valid(d2_rv)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rv_count = 0;

  // Effects scheduled by cycle number: what becomes visible in that cycle
  bit            fa_valid [0:DEPTH-1];
  bit            fa_last  [0:DEPTH-1];
  logic [SW-1:0] fa_sad   [0:DEPTH-1];
  logic [TW-1:0] fa_tag   [0:DEPTH-1];
  bit            init_at  [0:DEPTH-1];
  bit            rst_at   [0:DEPTH-1];

  logic [SW-1:0] m_sad;
  logic [TW-1:0] m_tag;
  bit            m_found, m_busy, m_rv;
  bit            chk_en = 1'b0;

  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] sb_e;
  bit            sb_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Best lane of a beat: the smallest masked SAD, then the first lane holding it
  function automatic void win(input logic [3:0] m, input logic [SW-1:0] s0, s1, s2, s3,
                              input logic [TW-1:0] base, stride,
                              output bit any, output logic [SW-1:0] sad,
                              output logic [TW-1:0] tag);
    logic [SW-1:0] sv[4];
    int idx;
    sv = '{s0, s1, s2, s3};
    any = 1'b0;
    sad = '1;
    idx = 0;
    for (int i = 0; i < 4; i++)
      if (m[i] && (!any || sv[i] < sad)) begin any = 1'b1; sad = sv[i]; end
    for (int i = 3; i >= 0; i--)
      if (m[i] && sv[i] == sad) idx = i;
    tag = base + TW'(idx) * stride;
  endfunction

  // ---------------- model + compare process ----------------
  always @(posedge Clk) begin
    cyc = cyc + 1;
    if (rst_at[cyc]) begin
      m_sad = '1; m_tag = '0; m_found = 1'b0; m_busy = 1'b0; m_rv = 1'b0;
      chk_en = 1'b1;
    end else if (init_at[cyc]) begin
      m_sad = '1; m_tag = '0; m_found = 1'b0; m_busy = 1'b1; m_rv = 1'b0;
    end else begin
      m_rv = fa_last[cyc];
      if (fa_valid[cyc] && fa_sad[cyc] < m_sad) begin
        m_sad = fa_sad[cyc]; m_tag = fa_tag[cyc]; m_found = 1'b1;
      end
      if (fa_last[cyc]) m_busy = 1'b0;
    end
    #1;
    if (chk_en) begin
      chk("min_sad", min_sad, m_sad);
      chk("min_tag", min_tag, m_tag);
      chk("found", found, m_found);
      chk("busy", busy, m_busy);
      chk("result_valid", result_valid, m_rv);
      chk("read_data", read_data, read_sel ? 32'(m_sad) : m_tag);
    end
    if (sb_en && result_valid) begin
      rv_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_result: actual=pulse required=none (cycle %0d)", cyc);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_min_sad", min_sad, 32'(sb_e[QW-1 -: SW]));
        chk("sb_min_tag", min_tag, sb_e[TW:1]);
        chk("sb_found", found, 32'(sb_e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drives one cycle of inputs, records their
  // scheduled effects, then advances to the next falling edge.
  task automatic beat(input bit st, v, l, input logic [3:0] m,
                      input logic [SW-1:0] s0, s1, s2, s3,
                      input logic [TW-1:0] base, stride);
    int n;
    bit any;
    logic [SW-1:0] ws;
    logic [TW-1:0] wt;
    start = st; cand_valid = v; cand_last = l; lane_mask = m;
    cand_sad = {s3, s2, s1, s0}; base_tag = base; tag_stride = stride;
    n = cyc;
    if (Reset) begin
      rst_at[n+1] = 1'b1; fa_valid[n+1] = 1'b0; fa_last[n+1] = 1'b0;
    end else begin
      if (st) begin
        init_at[n+1] = 1'b1; fa_valid[n+1] = 1'b0; fa_last[n+1] = 1'b0;
      end
      if (v) begin
        win(m, s0, s1, s2, s3, base, stride, any, ws, wt);
        fa_valid[n+2] = any; fa_sad[n+2] = ws; fa_tag[n+2] = wt; fa_last[n+2] = l;
      end
    end
    @(negedge Clk);
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 1'b0, 4'h0, '0, '0, '0, '0, '0, '0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit any;
    logic [SW-1:0] ws, acc_sad, r0, r1, r2, r3;
    logic [TW-1:0] wt, acc_tag;
    bit acc_found;
    logic [3:0] rm;

    Reset = 1'b1; start = 0; cand_valid = 0; cand_last = 0; read_sel = 0;
    cand_sad = '0; lane_mask = '0; base_tag = '0; tag_stride = '0;
    d2_start = 0; d2_valid = 0; d2_last = 0; d2_read_sel = 0;
    d2_sad = '0; d2_mask = '0; d2_base = '0; d2_stride = '0;

    @(negedge Clk);
    repeat (3) idle();
    Reset = 1'b0;
    idle();

    // Reset state
    chk("rst_min_sad", min_sad, 32'h1FFF);
    chk("rst_min_tag", min_tag, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_read_tag", read_data, 32'h0);
    read_sel = 1'b1;
    #1 chk("rst_read_sad", read_data, 32'h1FFF);
    read_sel = 1'b0;

    // Two lanes: lane1=40, lane0=25, one-beat search
    d2_start = 1; d2_valid = 1; d2_last = 1; d2_mask = 2'b11;
    d2_sad = {13'd40, 13'd25}; d2_base = 32'h100; d2_stride = 32'd4;
    idle();
    d2_start = 0; d2_valid = 0; d2_last = 0;
    chk("t1_rv_early", d2_rv, 32'h0);
    idle();
    chk("t1_rv", d2_rv, 32'h1);
    chk("t1_min_sad", d2_min_sad, 32'd25);
    chk("t1_min_tag", d2_min_tag, 32'h100);
    chk("t1_found", d2_found, 32'h1);
    idle();
    chk("t1_rv_once", d2_rv, 32'h0);

    // Ties: lowest lane, earliest beat
    beat(1, 1, 0, 4'hF, 7, 7, 9, 9, 32'h80, 32'd4);
    beat(0, 1, 1, 4'hF, 7, 7, 7, 7, 32'h200, 32'd4);
    idle();
    chk("t2_rv", result_valid, 32'h1);
    chk("t2_min_tag", min_tag, 32'h80);

    // Mask 1010
    beat(1, 1, 1, 4'b1010, 1, 50, 2, 60, 32'h0, 32'd8);
    idle();
    chk("t3_min_sad", min_sad, 32'd50);
    chk("t3_min_tag", min_tag, 32'd8);
    beat(0, 1, 1, 4'b0000, 0, 0, 0, 0, 32'h0, 32'd8);
    idle();
    chk("t3_mask0_rv", result_valid, 32'h1);
    chk("t3_mask0_sad", min_sad, 32'd50);

    // Saturated SADs never replace the initial minimum
    beat(1, 1, 1, 4'hF, 8191, 8191, 8191, 8191, 32'h40, 32'd4);
    idle();
    chk("t4_found", found, 32'h0);
    chk("t4_min_tag", min_tag, 32'h0);
    read_sel = 1'b1;
    #1 chk("t4_read_sad", read_data, 32'h1FFF);
    read_sel = 1'b0;

    // start discards the beat in stage 1
    beat(1, 1, 0, 4'h1, 3, 3, 3, 3, 32'h500, 32'd1);
    beat(1, 1, 1, 4'h1, 20, 20, 20, 20, 32'h600, 32'd1);
    idle();
    chk("t5_rv", result_valid, 32'h1);
    chk("t5_min_sad", min_sad, 32'd20);

    // Reset right after a last beat: no result
    beat(1, 1, 1, 4'hF, 5, 6, 7, 8, 32'h300, 32'd1);
    Reset = 1'b1;
    idle();
    Reset = 1'b0;
    idle();
    chk("t5_rst_rv", result_valid, 32'h0);
    chk("t5_rst_sad", min_sad, 32'h1FFF);
    idle();
    chk("t5_rst_rv_late", result_valid, 32'h0);

    // Beat without start folds; busy stays low
    beat(0, 1, 0, 4'hF, 100, 200, 300, 400, 32'h10, 32'd2);
    idle();
    chk("nostart_sad", min_sad, 32'd100);
    chk("nostart_busy", busy, 32'h0);

    // Consecutive last beats give two pulses
    beat(0, 1, 1, 4'hF, 50, 90, 90, 90, 32'h20, 32'd1);
    beat(0, 1, 1, 4'hF, 60, 40, 90, 90, 32'h30, 32'd1);
    idle();
    chk("b2b_rv2", result_valid, 32'h1);
    chk("b2b_tag", min_tag, 32'h31);

    // Back-to-back random searches with tag wrap
    sb_en = 1'b1;
    for (int s = 0; s < 10; s++) begin
      acc_sad = '1; acc_tag = '0; acc_found = 1'b0;
      for (int b = 0; b < 10; b++) begin
        rm = 4'($urandom_range(0, 15));
        r0 = SW'($urandom_range(0, 8191));
        r1 = SW'($urandom_range(0, 8191));
        r2 = SW'($urandom_range(0, 8191));
        r3 = SW'($urandom_range(0, 8191));
        win(rm, r0, r1, r2, r3, 32'hFFFF_FFF0, 32'h10, any, ws, wt);
        if (any && ws < acc_sad) begin
          acc_sad = ws; acc_tag = wt; acc_found = 1'b1;
        end
        beat(b == 0, 1, b == 9, rm, r0, r1, r2, r3, 32'hFFFF_FFF0, 32'h10);
        if (b == 9) exp_q.push_back({acc_sad, acc_tag, acc_found});
      end
      idle();
    end
    repeat (3) idle();
    sb_en = 1'b0;
    chk("t6_pulses", rv_count, 32'd10);
    chk("t6_queue_left", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
